// File: rtl/adder_carry_seq_par_amisha_if.sv
// ----------------------------------------------------------------------------
// adder_carry_seq_par_amisha_if : operand/result handshake bundle of the
// sliced carry adder/subtractor.   Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface adder_carry_seq_par_amisha_if #(
  parameter int N = 16
);
  logic         in_valid_amisha;
  logic         in_ready_amisha;
  logic [N-1:0] a_amisha;
  logic [N-1:0] b_amisha;
  logic         cin_amisha;
  logic         sub_amisha;
  logic         out_valid_amisha;
  logic         out_ready_amisha;
  logic [N-1:0] sum_amisha;
  logic         cout_amisha;
  logic         ovf_amisha;

  modport master (
    output in_valid_amisha,
    input  in_ready_amisha,
    output a_amisha,
    output b_amisha,
    output cin_amisha,
    output sub_amisha,
    input  out_valid_amisha,
    output out_ready_amisha,
    input  sum_amisha,
    input  cout_amisha,
    input  ovf_amisha
  );

  modport slave (
    input  in_valid_amisha,
    output in_ready_amisha,
    input  a_amisha,
    input  b_amisha,
    input  cin_amisha,
    input  sub_amisha,
    output out_valid_amisha,
    input  out_ready_amisha,
    output sum_amisha,
    output cout_amisha,
    output ovf_amisha
  );
endinterface

`default_nettype wire

// File: rtl/adder_carry_seq_par_amisha.sv
// ----------------------------------------------------------------------------
// adder_carry_seq_par_amisha : N-bit add/subtract, CHUNK bits per clock with a
// registered inter-slice carry and valid/ready on both sides.   Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module adder_carry_seq_par_amisha #(
  parameter int N     = 16,
  parameter int CHUNK = 4
) (
  input  logic                          clk_amisha,
  input  logic                          rst_n_amisha,
  adder_carry_seq_par_amisha_if.slave   bus
);

  localparam int NSLICE = N / CHUNK;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0] c_LAST_K = KW'(NSLICE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [N-1:0]    r_a;
  logic [N-1:0]    r_b;
  logic            r_carry;
  logic [KW-1:0]   r_k;
  logic [N-1:0]    r_sum;
  logic            r_cout;
  logic            r_ovf;
  logic            r_in_ready;
  logic            r_out_valid;

  logic [CHUNK-1:0] w_a_sl;
  logic [CHUNK-1:0] w_b_sl;
  logic [CHUNK-1:0] w_s;
  logic             w_c;
  logic             w_c_msb;
  logic             w_last;
  logic             w_accept;

  // Operands shift right each slice so the active slice is always at the bottom.
  assign w_a_sl   = r_a[CHUNK-1:0];
  assign w_b_sl   = r_b[CHUNK-1:0];
  assign {w_c, w_s} = {1'b0, w_a_sl} + {1'b0, w_b_sl} + {{CHUNK{1'b0}}, r_carry};
  // Carry into the top bit of the slice, recovered from its sum bit.
  assign w_c_msb  = w_s[CHUNK-1] ^ w_a_sl[CHUNK-1] ^ w_b_sl[CHUNK-1];
  assign w_last   = (r_k == c_LAST_K);
  assign w_accept = bus.in_valid_amisha && r_in_ready;

  always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
    if (!rst_n_amisha) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_carry     <= 1'b0;
      r_k         <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a        <= bus.a_amisha;
            r_b        <= bus.sub_amisha ? ~bus.b_amisha : bus.b_amisha;
            r_carry    <= bus.sub_amisha ? 1'b1 : bus.cin_amisha;
            r_k        <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_ADD;
          end
        end

        S_ADD: begin
          for (int i = 0; i < NSLICE; i++) begin
            if (r_k == KW'(i)) begin
              r_sum[i*CHUNK +: CHUNK] <= w_s;
            end
          end
          r_a     <= r_a >> CHUNK;
          r_b     <= r_b >> CHUNK;
          r_carry <= w_c;
          r_k     <= r_k + KW'(1);
          if (w_last) begin
            r_cout      <= w_c;
            r_ovf       <= w_c_msb ^ w_c;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end

        S_DONE: begin
          if (bus.out_ready_amisha) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_k         <= '0;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready_amisha  = r_in_ready;
  assign bus.out_valid_amisha = r_out_valid;
  assign bus.sum_amisha       = r_sum;
  assign bus.cout_amisha      = r_cout;
  assign bus.ovf_amisha       = r_ovf;

endmodule

`default_nettype wire
